// File: rtl/p5_writeback_if.sv
// Write-back stage bundle: decoded-phase inputs, register-file/flag/branch results
// and the out_data/out_valid/out_ready handshake toward the external sink.
interface p5_writeback_if;
    logic [2:0]  state;
    logic [15:0] instruction_register;
    logic [15:0] data_register;
    logic [3:0]  cond;
    logic [15:0] mdr;
    logic        out_ready;

    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic [3:0]  szcv;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] out_data;
    logic        out_valid;
    logic        stall;
    logic        halted;
    logic [15:0] retired;

    modport master (
        output state, instruction_register, data_register, cond, mdr, out_ready,
        input  reg_we, reg_waddr, reg_wdata, szcv, pc_load, pc_target,
               out_data, out_valid, stall, halted, retired
    );

    modport slave (
        input  state, instruction_register, data_register, cond, mdr, out_ready,
        output reg_we, reg_waddr, reg_wdata, szcv, pc_load, pc_target,
               out_data, out_valid, stall, halted, retired
    );
endinterface

// File: rtl/p5_writeback.sv
// P5 write-back stage: register-file write, flag update, branch resolution,
// buffered output port with back-pressure, halt latch and retirement counter.
module p5_writeback (
    input  logic           clock,
    input  logic           reset,
    p5_writeback_if.slave  bus
);
    logic [1:0]  w_op;
    logic [3:0]  w_op3;
    logic [2:0]  w_rs;
    logic [2:0]  w_rd;
    logic [2:0]  w_op2;
    logic [2:0]  w_bcond;

    logic        w_active;
    logic        w_alu;
    logic        w_is_out;
    logic        w_is_hlt;
    logic        w_alu_wr;
    logic        w_flags_ld;
    logic        w_is_ld;
    logic        w_is_li;
    logic        w_cond_true;
    logic        w_taken;
    logic        w_stall;
    logic        w_out_accept;
    logic        w_retire;

    logic [3:0]  r_szcv;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic        r_halted;
    logic [15:0] r_retired;

    assign w_op    = bus.instruction_register[15:14];
    assign w_op3   = bus.instruction_register[7:4];
    assign w_rs    = bus.instruction_register[13:11];
    assign w_rd    = bus.instruction_register[10:8];
    assign w_op2   = bus.instruction_register[13:11];
    assign w_bcond = bus.instruction_register[10:8];

    assign w_active   = (bus.state == 3'd4) && !r_halted;
    assign w_alu      = (w_op == 2'b11);
    assign w_is_out   = w_alu && (w_op3 == 4'd13);
    assign w_is_hlt   = w_alu && (w_op3 == 4'd15);
    // CMP (5) only sets flags; op3 7 is a non-writing slot
    assign w_alu_wr   = w_alu && (w_op3 <= 4'd12) && (w_op3 != 4'd5) && (w_op3 != 4'd7);
    assign w_flags_ld = w_alu && (w_op3 <= 4'd11) && (w_op3 != 4'd7);
    assign w_is_ld    = (w_op == 2'b00);
    assign w_is_li    = (w_op == 2'b10) && (w_op2 == 3'b000);

    // Conditions evaluate the registered flags {S,Z,C,V}, never the live cond input
    always_comb begin
        w_cond_true = 1'b0;
        case (w_bcond)
            3'd0:    w_cond_true = r_szcv[2];
            3'd1:    w_cond_true = r_szcv[3] ^ r_szcv[0];
            3'd2:    w_cond_true = r_szcv[2] | (r_szcv[3] ^ r_szcv[0]);
            3'd3:    w_cond_true = !r_szcv[2];
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_taken = (w_op == 2'b10) &&
                     ((w_op2 == 3'b100) || ((w_op2 == 3'b111) && w_cond_true));

    assign w_stall      = w_active && w_is_out && r_out_valid && !bus.out_ready;
    assign w_out_accept = w_active && w_is_out && !w_stall;
    assign w_retire     = w_active && !w_stall;

    assign bus.reg_we    = w_active && (w_alu_wr || w_is_ld || w_is_li);
    assign bus.reg_waddr = w_is_ld ? w_rs : w_rd;
    assign bus.reg_wdata = w_is_ld ? bus.mdr : bus.data_register;
    assign bus.pc_load   = w_active && w_taken;
    assign bus.pc_target = bus.data_register;
    assign bus.stall     = w_stall;
    assign bus.szcv      = r_szcv;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.halted    = r_halted;
    assign bus.retired   = r_retired;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_szcv      <= 4'd0;
            r_out_data  <= 16'd0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_retired   <= 16'd0;
        end else begin
            if (w_active && w_flags_ld)
                r_szcv <= bus.cond;
            // A push wins over a pop so simultaneous pop+push keeps valid high
            if (w_out_accept) begin
                r_out_data  <= bus.data_register;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_active && w_is_hlt)
                r_halted <= 1'b1;
            if (w_retire)
                r_retired <= r_retired + 16'd1;
        end
    end
endmodule

// File: tb/tb_p5_writeback.sv
// Self-checking bench for p5_writeback: behavioural model compared every cycle
// plus directed vectors with hand-computed expectations.
module tb_p5_writeback;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    logic quiet = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    p5_writeback_if bus();

    p5_writeback dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [3:0]  m_szcv      = 4'd0;
    logic [15:0] m_out_data  = 16'd0;
    logic        m_out_valid = 1'b0;
    logic        m_halted    = 1'b0;
    logic [15:0] m_retired   = 16'd0;

    function automatic logic m_writes(input logic [15:0] ir);
        case (ir[15:14])
            2'b00:   return 1'b1;
            2'b01:   return 1'b0;
            2'b10:   return ir[13:11] == 3'b000;
            default: return ir[7:4] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
                                            4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        endcase
    endfunction

    function automatic logic m_sets_flags(input logic [15:0] ir);
        return (ir[15:14] == 2'b11) &&
               (ir[7:4] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd8, 4'd9, 4'd10, 4'd11});
    endfunction

    function automatic logic m_taken(input logic [15:0] ir, input logic [3:0] f);
        logic s, z, v;
        s = f[3]; z = f[2]; v = f[0];
        if (ir[15:14] != 2'b10) return 1'b0;
        if (ir[13:11] == 3'b100) return 1'b1;
        if (ir[13:11] != 3'b111) return 1'b0;
        if (ir[10:8] == 3'd0) return z;
        if (ir[10:8] == 3'd1) return s != v;
        if (ir[10:8] == 3'd2) return z || (s != v);
        if (ir[10:8] == 3'd3) return !z;
        return 1'b0;
    endfunction

    function automatic logic m_is_out(input logic [15:0] ir);
        return (ir[15:14] == 2'b11) && (ir[7:4] == 4'd13);
    endfunction

    function automatic logic m_is_hlt(input logic [15:0] ir);
        return (ir[15:14] == 2'b11) && (ir[7:4] == 4'd15);
    endfunction

    always @(negedge reset) begin
        m_szcv      = 4'd0;
        m_out_data  = 16'd0;
        m_out_valid = 1'b0;
        m_halted    = 1'b0;
        m_retired   = 16'd0;
    end

    always @(posedge clock) begin
        if (reset) begin
            logic act, blocked, pushed;
            act     = (bus.state == 3'd4) && !m_halted;
            blocked = act && m_is_out(bus.instruction_register) && m_out_valid && !bus.out_ready;
            pushed  = act && m_is_out(bus.instruction_register) && !blocked;
            if (act && !blocked) begin
                m_retired = m_retired + 16'd1;
                if (m_sets_flags(bus.instruction_register)) m_szcv = bus.cond;
                if (m_is_hlt(bus.instruction_register)) m_halted = 1'b1;
            end
            if (pushed) begin
                m_out_data  = bus.data_register;
                m_out_valid = 1'b1;
            end else if (m_out_valid && bus.out_ready) begin
                m_out_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            logic act, exp_we;
            act    = (bus.state == 3'd4) && !m_halted;
            exp_we = act && m_writes(bus.instruction_register);
            chk("model reg_we", {31'd0, bus.reg_we}, {31'd0, exp_we});
            if (exp_we) begin
                chk("model reg_waddr", {29'd0, bus.reg_waddr},
                    {29'd0, (bus.instruction_register[15:14] == 2'b00) ?
                            bus.instruction_register[13:11] : bus.instruction_register[10:8]});
                chk("model reg_wdata", {16'd0, bus.reg_wdata},
                    {16'd0, (bus.instruction_register[15:14] == 2'b00) ? bus.mdr : bus.data_register});
            end
            chk("model pc_load", {31'd0, bus.pc_load},
                {31'd0, act && m_taken(bus.instruction_register, m_szcv)});
            chk("model pc_target", {16'd0, bus.pc_target}, {16'd0, bus.data_register});
            chk("model stall", {31'd0, bus.stall},
                {31'd0, act && m_is_out(bus.instruction_register) && m_out_valid && !bus.out_ready});
            chk("model szcv", {28'd0, bus.szcv}, {28'd0, m_szcv});
            chk("model out_valid", {31'd0, bus.out_valid}, {31'd0, m_out_valid});
            chk("model out_data", {16'd0, bus.out_data}, {16'd0, m_out_data});
            chk("model halted", {31'd0, bus.halted}, {31'd0, m_halted});
            chk("model retired", {16'd0, bus.retired}, {16'd0, m_retired});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] st, input logic [15:0] ir, input logic [15:0] dr,
                         input logic [3:0] cnd, input logic [15:0] md, input logic rdy);
        bus.state                = st;
        bus.instruction_register = ir;
        bus.data_register        = dr;
        bus.cond                 = cnd;
        bus.mdr                  = md;
        bus.out_ready            = rdy;
        if (!quiet)
            $display("txn t=%0t state=%0d ir=%h dr=%h cond=%b mdr=%h out_ready=%0b",
                     $time, st, ir, dr, cnd, md, rdy);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(3'd0, 16'h4000, 16'h0000, 4'd0, 16'h0000, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("reset szcv", {28'd0, bus.szcv}, 32'd0);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset halted", {31'd0, bus.halted}, 32'd0);
        chk("reset retired", {16'd0, bus.retired}, 32'd0);
        chk("reset reg_we", {31'd0, bus.reg_we}, 32'd0);
        tick();
        reset = 1'b1;
        chk_en = 1'b1;

        // ADD r3
        drive(3'd4, 16'hC300, 16'h1234, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("ADD reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("ADD reg_waddr", {29'd0, bus.reg_waddr}, 32'd3);
        chk("ADD reg_wdata", {16'd0, bus.reg_wdata}, 32'h1234);
        tick();
        chk("ADD szcv", {28'd0, bus.szcv}, 32'd0);
        chk("ADD retired", {16'd0, bus.retired}, 32'd1);

        // CMP then branches on the registered flags
        drive(3'd4, 16'hC050, 16'h0000, 4'b0100, 16'h0000, 1'b0);
        #1;
        chk("CMP reg_we", {31'd0, bus.reg_we}, 32'd0);
        tick();
        chk("CMP szcv", {28'd0, bus.szcv}, 32'b0100);
        drive(3'd4, 16'hB805, 16'h0040, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("BE pc_load", {31'd0, bus.pc_load}, 32'd1);
        chk("BE pc_target", {16'd0, bus.pc_target}, 32'h0040);
        tick();
        drive(3'd4, 16'hBB00, 16'h0040, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("BNE pc_load", {31'd0, bus.pc_load}, 32'd0);
        tick();
        drive(3'd4, 16'hB900, 16'h0050, 4'b1000, 16'h0000, 1'b0);
        #1;
        chk("BLT pc_load", {31'd0, bus.pc_load}, 32'd0);
        tick();
        drive(3'd4, 16'hBA00, 16'h0060, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("BLE pc_load", {31'd0, bus.pc_load}, 32'd1);
        tick();
        drive(3'd4, 16'hA000, 16'h0070, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("BR pc_load", {31'd0, bus.pc_load}, 32'd1);
        tick();
        drive(3'd4, 16'h8800, 16'h0080, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("op2=001 pc_load", {31'd0, bus.pc_load}, 32'd0);
        chk("op2=001 reg_we", {31'd0, bus.reg_we}, 32'd0);
        tick();

        // LI r5, LD r2
        drive(3'd4, 16'h8500, 16'h5555, 4'b1111, 16'h0000, 1'b0);
        #1;
        chk("LI reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("LI reg_waddr", {29'd0, bus.reg_waddr}, 32'd5);
        tick();
        drive(3'd4, 16'h1000, 16'h7777, 4'b1111, 16'hBEEF, 1'b0);
        #1;
        chk("LD reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("LD reg_waddr", {29'd0, bus.reg_waddr}, 32'd2);
        chk("LD reg_wdata", {16'd0, bus.reg_wdata}, 32'hBEEF);
        tick();
        chk("LD szcv", {28'd0, bus.szcv}, 32'b0100);
        chk("LD retired", {16'd0, bus.retired}, 32'd10);

        // Not in P5, ST, and the non-writing / non-flag ALU slots
        drive(3'd3, 16'hC300, 16'h9999, 4'b1111, 16'h0000, 1'b0);
        #1;
        chk("idle reg_we", {31'd0, bus.reg_we}, 32'd0);
        tick();
        chk("idle retired", {16'd0, bus.retired}, 32'd10);
        drive(3'd4, 16'h4000, 16'h0000, 4'b1111, 16'h0000, 1'b0);
        tick();
        drive(3'd4, 16'hC070, 16'h0000, 4'b1111, 16'h0000, 1'b0);
        tick();
        chk("op3=7 szcv", {28'd0, bus.szcv}, 32'b0100);
        drive(3'd4, 16'hC0C0, 16'hAAAA, 4'b1111, 16'h0000, 1'b0);
        #1;
        chk("op3=12 reg_we", {31'd0, bus.reg_we}, 32'd1);
        tick();
        chk("op3=12 szcv", {28'd0, bus.szcv}, 32'b0100);
        drive(3'd4, 16'hC0E0, 16'h0000, 4'b1111, 16'h0000, 1'b0);
        tick();

        // OUT twice with the sink not ready, then release
        drive(3'd4, 16'hC0D0, 16'h1111, 4'b0000, 16'h0000, 1'b0);
        tick();
        chk("OUT1 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("OUT1 out_data", {16'd0, bus.out_data}, 32'h1111);
        drive(3'd4, 16'hC0D0, 16'h2222, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("OUT2 stall", {31'd0, bus.stall}, 32'd1);
        tick();
        tick();
        chk("OUT2 retired frozen", {16'd0, bus.retired}, 32'd15);
        chk("OUT2 data held", {16'd0, bus.out_data}, 32'h1111);
        drive(3'd4, 16'hC0D0, 16'h2222, 4'b0000, 16'h0000, 1'b1);
        #1;
        chk("OUT2 ready stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("OUT2 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("OUT2 out_data", {16'd0, bus.out_data}, 32'h2222);
        drive(3'd0, 16'h4000, 16'h0000, 4'b0000, 16'h0000, 1'b1);
        tick();
        chk("pop out_valid", {31'd0, bus.out_valid}, 32'd0);

        // HLT with a pending output, drain while halted, async reset mid-cycle
        drive(3'd4, 16'hC0D0, 16'h3333, 4'b0000, 16'h0000, 1'b0);
        tick();
        drive(3'd4, 16'hC0F0, 16'h0000, 4'b0000, 16'h0000, 1'b0);
        tick();
        chk("HLT halted", {31'd0, bus.halted}, 32'd1);
        chk("HLT retired", {16'd0, bus.retired}, 32'd18);
        drive(3'd4, 16'hC300, 16'h4444, 4'b1010, 16'h0000, 1'b0);
        #1;
        chk("halted reg_we", {31'd0, bus.reg_we}, 32'd0);
        tick();
        chk("halted retired", {16'd0, bus.retired}, 32'd18);
        chk("halted out_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(3'd4, 16'hC300, 16'h4444, 4'b1010, 16'h0000, 1'b1);
        tick();
        chk("halted drain", {31'd0, bus.out_valid}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async halted", {31'd0, bus.halted}, 32'd0);
        chk("async retired", {16'd0, bus.retired}, 32'd0);
        chk("async szcv", {28'd0, bus.szcv}, 32'd0);
        tick();
        reset = 1'b1;

        // Reset while an OUT is stalled drops it
        drive(3'd4, 16'hC0D0, 16'h5A5A, 4'b0000, 16'h0000, 1'b0);
        tick();
        drive(3'd4, 16'hC0D0, 16'hA5A5, 4'b0000, 16'h0000, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("stall reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall reset stall", {31'd0, bus.stall}, 32'd0);
        tick();
        reset = 1'b1;
        drive(3'd0, 16'h4000, 16'h0000, 4'b0000, 16'h0000, 1'b1);
        tick();

        // Retirement counter wrap
        reset = 1'b0;
        tick();
        reset = 1'b1;
        quiet = 1'b1;
        drive(3'd4, 16'h4000, 16'h0000, 4'b0000, 16'h0000, 1'b0);
        repeat (65535) tick();
        chk("retired max", {16'd0, bus.retired}, 32'h0000FFFF);
        tick();
        chk("retired wrap", {16'd0, bus.retired}, 32'd0);
        quiet = 1'b0;

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
